// File: rtl/shared_buf_arbiter_if.sv
// Handshake bundle between buffer requesters and the shared-buffer arbiter.
// The master side drives the request, release and configuration; the slave side returns grant status.
interface shared_buf_arbiter_if #(
    parameter int NUM_REQ   = 2,
    parameter int TIMEOUT_W = 16,
    parameter int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic                 enable;
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   rel;
    logic [TIMEOUT_W-1:0] timeout_cycles;
    logic [NUM_REQ-1:0]   grant;
    logic                 owner_valid;
    logic [IDX_W-1:0]     owner_idx;
    logic                 timeout_pulse;
    logic [IDX_W-1:0]     timeout_idx;

    modport master (
        output enable, req, rel, timeout_cycles,
        input  grant, owner_valid, owner_idx, timeout_pulse, timeout_idx
    );

    modport slave (
        input  enable, req, rel, timeout_cycles,
        output grant, owner_valid, owner_idx, timeout_pulse, timeout_idx
    );
endinterface

// File: rtl/shared_buf_arbiter.sv
// Ownership arbiter for buffers shared between CPU and HLS cores: registered one-hot grant,
// fixed or round-robin pick, optional default owner, enable gate and hold-timeout release.
module shared_buf_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int RR_MODE     = 1,
    parameter int RESET_OWNER = -1,
    parameter int TIMEOUT_W   = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    shared_buf_arbiter_if.slave bus
);
    // state   | meaning
    // IDLE    | no owner; req winner (or default owner) is granted next cycle
    // GRANTED | owner_q holds the buffer until rel, hold timeout or enable low
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE = 1'b0, GRANTED = 1'b1} state_t;

    localparam state_t               RST_STATE = (RESET_OWNER >= 0) ? GRANTED : IDLE;
    localparam logic [IDX_W-1:0]     RST_IDX   = IDX_W'((RESET_OWNER >= 0) ? RESET_OWNER : 0);
    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [TIMEOUT_W-1:0] TMO_ONE   = TIMEOUT_W'(1);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     tidx_q, tidx_d;
    logic [TIMEOUT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic                 tpulse_q, tpulse_d;
    logic                 win_found;
    logic [IDX_W-1:0]     win_idx, cand, owner_next;
    logic                 timeout_hit, granted;

    // Scan starts at rr_ptr in round-robin mode, at index 0 in fixed-priority mode.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (RR_MODE != 0) cand = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            else              cand = IDX_W'(i);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign owner_next  = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
    assign timeout_hit = (bus.timeout_cycles != '0) &&
                         (hold_cnt_q == bus.timeout_cycles - TMO_ONE);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        tpulse_d   = 1'b0;
        tidx_d     = tidx_q;
        if (!bus.enable) begin
            state_d    = RST_STATE;
            owner_d    = RST_IDX;
            hold_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (win_found) begin
                        state_d    = GRANTED;
                        owner_d    = win_idx;
                        hold_cnt_d = '0;
                    end else if (RESET_OWNER >= 0) begin
                        state_d    = GRANTED;
                        owner_d    = RST_IDX;
                        hold_cnt_d = '0;
                    end
                end
                GRANTED: begin
                    if (bus.rel[owner_q]) begin
                        state_d  = IDLE;
                        rr_ptr_d = owner_next;
                    end else if (timeout_hit) begin
                        state_d  = IDLE;
                        rr_ptr_d = owner_next;
                        tpulse_d = 1'b1;
                        tidx_d   = owner_q;
                    end else if (hold_cnt_q != '1) begin
                        hold_cnt_d = hold_cnt_q + TMO_ONE;
                    end
                end
                default: state_d = RST_STATE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RST_STATE;
            owner_q    <= RST_IDX;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            tpulse_q   <= 1'b0;
            tidx_q     <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            tpulse_q   <= tpulse_d;
            tidx_q     <= tidx_d;
        end
    end

    // Enable masks the registered grant without waiting for the state to follow.
    assign granted           = bus.enable && (state_q == GRANTED);
    assign bus.grant         = granted ? (NUM_REQ'(1) << owner_q) : '0;
    assign bus.owner_valid   = granted;
    assign bus.owner_idx     = granted ? owner_q : '0;
    assign bus.timeout_pulse = tpulse_q;
    assign bus.timeout_idx   = tidx_q;
endmodule
